// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller: time-slices the anodes,
// latches a whole frame of digits at once and blanks leading zeros.

// Per-digit leading-zero detect. A digit is dark when blanking is on and it and
// every nibble above it are zero. The rightmost digit always stays lit.
module seg_lane #(
  parameter int IDX = 0
) (
  input  logic [15:0] digits,
  input  logic        lz,
  output logic        blank
);
  assign blank = (IDX != 0) && lz && ((digits >> (4 * IDX)) == 16'h0000);
endmodule

module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an_n,
  output logic [3:0]  digit_out,
  output logic        dp_n,
  output logic        frame_tick
);
  localparam int NUM_DIG = 4;
  localparam int CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]        cnt;
  logic [1:0]           slot;
  logic [15:0]          sh_digits;
  logic [3:0]           sh_dp;
  logic                 sh_lz;

  logic                 wrap, frame_end, in_blank, lit;
  logic [NUM_DIG-1:0]   lane_blank;
  logic [3:0]           an_d, dig_d;
  logic                 dp_d, ft_d;

  assign wrap      = (cnt == CNT_LAST);
  assign frame_end = wrap && (slot == 2'd3);

  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < CW'(BLANK_CYC));
    end
  endgenerate

  generate
    for (genvar i = 0; i < NUM_DIG; i++) begin : g_lane
      seg_lane #(.IDX(i)) u_lane (
        .digits (sh_digits),
        .lz     (sh_lz),
        .blank  (lane_blank[i])
      );
    end
  endgenerate

  // Scan position and frame shadows. While disabled the shadows track the
  // inputs so a re-enabled scan starts from the latest values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      slot      <= '0;
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_lz     <= 1'b0;
    end else if (!enable) begin
      cnt       <= '0;
      slot      <= '0;
      sh_digits <= digits_in;
      sh_dp     <= dp_in;
      sh_lz     <= blank_lz;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) slot <= slot + 2'd1;
      if (frame_end) begin
        sh_digits <= digits_in;
        sh_dp     <= dp_in;
        sh_lz     <= blank_lz;
      end
    end
  end

  // Output stage sees the state one cycle old; enable is sampled directly so
  // dropping it darkens the display on the very next edge.
  always_comb begin
    an_d  = 4'hF;
    dp_d  = 1'b1;
    lit   = enable && !in_blank && !lane_blank[slot];
    dig_d = sh_digits[{slot, 2'b00} +: 4];
    ft_d  = enable && frame_end;
    if (lit) begin
      an_d[slot] = 1'b0;
      dp_d       = ~sh_dp[slot];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= 4'hF;
      digit_out  <= 4'h0;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an_n       <= an_d;
      digit_out  <= dig_d;
      dp_n       <= dp_d;
      frame_tick <= ft_d;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a position-in-frame reference model.
module tb_seg_scan_ctrl;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an_n, digit_out;
  logic        dp_n, frame_tick;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: position within the frame plus frame-latched inputs.
  int          pos;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic        m_lz;
  logic [3:0]  e_an, e_dig;
  logic        e_dp, e_ft;
  int          cyc = 0;
  int          last_tick = -1;

  seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .an_n       (an_n),
    .digit_out  (digit_out),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pos = 0; m_dig = 16'h0; m_dp = 4'h0; m_lz = 1'b0;
    e_an = 4'hF; e_dig = 4'h0; e_dp = 1'b1; e_ft = 1'b0;
    last_tick = -1;
  endtask

  task automatic model_edge();
    int s, c;
    logic lit;
    logic [3:0] oh;
    s   = pos / RD;
    c   = pos % RD;
    lit = enable && (c >= BC) && !(s != 0 && m_lz && ((m_dig >> (4 * s)) == 16'h0));
    oh  = 4'b0001 << s;
    e_an  = lit ? ~oh : 4'hF;
    e_dig = 4'((m_dig >> (4 * s)) & 16'hF);
    e_dp  = lit ? ~m_dp[s] : 1'b1;
    e_ft  = enable && (pos == FR - 1);
    if (!enable) pos = 0;
    else pos = (pos + 1) % FR;
    if (!enable || pos == 0) begin
      m_dig = digits_in; m_dp = dp_in; m_lz = blank_lz;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_an", 32'(an_n), 32'hF);
    chk("rst_dig", 32'(digit_out), 32'h0);
    chk("rst_dp", 32'(dp_n), 32'h1);
    chk("rst_ft", 32'(frame_tick), 32'h0);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      chk("an_n", 32'(an_n), 32'(e_an));
      chk("digit_out", 32'(digit_out), 32'(e_dig));
      chk("dp_n", 32'(dp_n), 32'(e_dp));
      chk("frame_tick", 32'(frame_tick), 32'(e_ft));
      chk("an_onehot", 32'($countones(~an_n) <= 1), 32'h1);
      if (!enable) last_tick = -1;
      if (frame_tick) begin
        if (last_tick >= 0) chk("tick_gap", 32'(cyc - last_tick), 32'(FR));
        last_tick = cyc;
      end
    end
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals();

    // First frame shows reset shadows, second shows 1234
    enable = 1'b1; digits_in = 16'h1234; rst_n = 1'b1;
    step(3);
    chk("f1_an", 32'(an_n), 32'hE);
    chk("f1_dig", 32'(digit_out), 32'h0);
    step(29);
    chk("f1_tick", 32'(frame_tick), 32'h1);
    step(2);
    chk("f2_blank", 32'(an_n), 32'hF);
    step(1);
    chk("f2_s0_an", 32'(an_n), 32'hE);
    chk("f2_s0_dig", 32'(digit_out), 32'h4);
    step(8);
    chk("f2_s1_an", 32'(an_n), 32'hD);
    chk("f2_s1_dig", 32'(digit_out), 32'h3);
    step(FR);

    // Leading-zero blanking
    @(negedge clk); digits_in = 16'h0070; blank_lz = 1'b1;
    step(2 * FR);

    // Mid-frame change must not tear
    @(negedge clk); digits_in = 16'h1111; blank_lz = 1'b0;
    step(2 * FR - 1);
    step(RD + 3);
    @(negedge clk); digits_in = 16'h2222;
    step(2 * FR);

    // Decimal point on digit 2
    @(negedge clk); dp_in = 4'b0100;
    step(2 * FR);

    // Drop enable inside slot 2, then resume with new inputs
    while (!(pos / RD == 2 && pos % RD == 4)) step(1);
    @(negedge clk); enable = 1'b0;
    step(1);
    chk("dis_an", 32'(an_n), 32'hF);
    chk("dis_dp", 32'(dp_n), 32'h1);
    step(3);
    @(negedge clk); digits_in = 16'h5678; dp_in = 4'b0001;
    step(2);
    @(negedge clk); enable = 1'b1;
    step(2 * FR);

    // Reset mid-slot
    step(13);
    async_reset();
    step(2 * FR);

    // Random traffic
    repeat (1500) begin
      @(negedge clk);
      r = $urandom();
      if ($urandom_range(0, 15) == 0) digits_in = 16'(r[15:0] >> (4 * $urandom_range(0, 3)));
      if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom());
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 39) == 0) enable = ($urandom_range(0, 3) != 0);
      step(1);
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
